// File: rtl/tx_order_arbiter.sv
// Shares one order-transmit port among N_REQ requesters with round-robin grant and cycle timestamping.
// Build option: define ARB_FIXED_PRIO_EN for strict fixed priority (index 0 highest, no rotation pointer).
module tx_order_arbiter #(
  parameter int N_REQ = 4,
  parameter int TS_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_addr,
  input  logic [8*N_REQ-1:0]   req_buysell,
  output logic [N_REQ-1:0]     req_ready,
  input  logic                 tx_ready,
  output logic [7:0]           tx_addr,
  output logic [7:0]           tx_buysell,
  output logic [TS_W-1:0]      tx_timestamp,
  output logic                 tx_dv
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [TS_W-1:0]   ts_cnt_q, ts_cnt_d;
  logic [7:0]        tx_addr_q, tx_addr_d;
  logic [7:0]        tx_buysell_q, tx_buysell_d;
  logic [TS_W-1:0]   tx_ts_q, tx_ts_d;
  logic              tx_dv_q, tx_dv_d;
  logic [N_REQ-1:0]  req_ready_q, req_ready_d;

  logic              found;
  logic [IDX_W-1:0]  win;
  int unsigned       srch_start;
  int unsigned       srch_idx;

`ifndef ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  win_q, win_d;
`endif

  // Rotating search: first valid requester at or after the start index, wrapping mod N_REQ.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    srch_idx = 0;
`ifdef ARB_FIXED_PRIO_EN
    srch_start = 0;
`else
    srch_start = int'(rr_ptr_q);
`endif
    for (int unsigned i = 0; i < N_REQ; i++) begin
      srch_idx = (srch_start + i) % N_REQ;
      if (!found && req_valid[IDX_W'(srch_idx)]) begin
        found = 1'b1;
        win   = IDX_W'(srch_idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    ts_cnt_d     = ts_cnt_q + TS_W'(1);
    tx_addr_d    = tx_addr_q;
    tx_buysell_d = tx_buysell_q;
    tx_ts_d      = tx_ts_q;
    tx_dv_d      = tx_dv_q;
    req_ready_d  = '0;
`ifndef ARB_FIXED_PRIO_EN
    rr_ptr_d     = rr_ptr_q;
    win_d        = win_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (found) begin
          tx_addr_d    = req_addr[8*win +: 8];
          tx_buysell_d = req_buysell[8*win +: 8];
          tx_ts_d      = ts_cnt_q;
          tx_dv_d      = 1'b1;
          req_ready_d  = N_REQ'(1) << win;
`ifndef ARB_FIXED_PRIO_EN
          win_d        = win;
`endif
          state_d      = HOLD;
        end
      end
      HOLD: begin
        if (tx_ready) begin
          tx_dv_d  = 1'b0;
`ifndef ARB_FIXED_PRIO_EN
          rr_ptr_d = IDX_W'((int'(win_q) + 1) % N_REQ);
`endif
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ts_cnt_q     <= '0;
      tx_addr_q    <= '0;
      tx_buysell_q <= '0;
      tx_ts_q      <= '0;
      tx_dv_q      <= 1'b0;
      req_ready_q  <= '0;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q     <= '0;
      win_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ts_cnt_q     <= ts_cnt_d;
      tx_addr_q    <= tx_addr_d;
      tx_buysell_q <= tx_buysell_d;
      tx_ts_q      <= tx_ts_d;
      tx_dv_q      <= tx_dv_d;
      req_ready_q  <= req_ready_d;
`ifndef ARB_FIXED_PRIO_EN
      rr_ptr_q     <= rr_ptr_d;
      win_q        <= win_d;
`endif
    end
  end

  assign tx_addr      = tx_addr_q;
  assign tx_buysell   = tx_buysell_q;
  assign tx_timestamp = tx_ts_q;
  assign tx_dv        = tx_dv_q;
  assign req_ready    = req_ready_q;

endmodule

// File: tb/tb_tx_order_arbiter.sv
// Directed bench for tx_order_arbiter: expected grants are queued as stimulus is driven and checked on output.
module tb_tx_order_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_buysell;
  logic [3:0]  req_ready;
  logic        tx_ready;
  logic [7:0]  tx_addr;
  logic [7:0]  tx_buysell;
  logic [31:0] tx_timestamp;
  logic        tx_dv;

  logic [1:0]  w_valid;
  logic [15:0] w_addr;
  logic [15:0] w_bs;
  logic [1:0]  w_ready;
  logic        w_tx_ready;
  logic [7:0]  w_tx_addr;
  logic [7:0]  w_tx_bs;
  logic [3:0]  w_ts;
  logic        w_dv;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_ts;
  logic [7:0]  pa [4];
  logic [7:0]  pb [4];

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] ts;
    logic [3:0]  rdy;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;

  tx_order_arbiter #(.N_REQ(4), .TS_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_buysell(req_buysell), .req_ready(req_ready), .tx_ready(tx_ready),
    .tx_addr(tx_addr), .tx_buysell(tx_buysell), .tx_timestamp(tx_timestamp), .tx_dv(tx_dv)
  );

  tx_order_arbiter #(.N_REQ(2), .TS_W(4)) dut_wrap (
    .clk(clk), .reset_n(reset_n), .req_valid(w_valid), .req_addr(w_addr),
    .req_buysell(w_bs), .req_ready(w_ready), .tx_ready(w_tx_ready),
    .tx_addr(w_tx_addr), .tx_buysell(w_tx_bs), .tx_timestamp(w_ts), .tx_dv(w_dv)
  );

  // Reference free-running cycle count since the last reset release.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_ts <= '0;
    else          m_ts <= m_ts + 32'd1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_grant(input int idx);
    exp_t e;
    e.a   = pa[idx];
    e.b   = pb[idx];
    e.ts  = m_ts;
    e.rdy = 4'(1 << idx);
    sb.push_back(e);
  endtask

  task automatic check_grant(input string tag);
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      cur = sb.pop_front();
      chk({tag, "_dv"},   tx_dv, 1'b1);
      chk({tag, "_addr"}, tx_addr, cur.a);
      chk({tag, "_bs"},   tx_buysell, cur.b);
      chk({tag, "_ts"},   tx_timestamp, cur.ts);
      chk({tag, "_rdy"},  req_ready, cur.rdy);
    end
  endtask

  task automatic chk_hold(input string tag);
    chk({tag, "_dv"},   tx_dv, 1'b1);
    chk({tag, "_rdy"},  req_ready, 4'b0000);
    chk({tag, "_addr"}, tx_addr, cur.a);
    chk({tag, "_bs"},   tx_buysell, cur.b);
    chk({tag, "_ts"},   tx_timestamp, cur.ts);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_dv"},  tx_dv, 1'b0);
    chk({tag, "_rdy"}, req_ready, 4'b0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rr_seq [5];
`ifdef ARB_FIXED_PRIO_EN
    rr_seq = '{0, 0, 0, 0, 0};
`else
    rr_seq = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      pa[i] = 8'h10 + 8'(i);
      pb[i] = (i == 2) ? 8'h01 : 8'hB0 + 8'(i);
      req_addr[8*i +: 8]    = pa[i];
      req_buysell[8*i +: 8] = pb[i];
    end
    reset_n = 1'b0; req_valid = '0; tx_ready = 1'b0;
    w_valid = '0; w_addr = 16'h2120; w_bs = 16'h3130; w_tx_ready = 1'b1;

    repeat (3) tick();
    chk_idle("rst");
    chk("rst_addr", tx_addr, 8'h00);
    chk("rst_bs",   tx_buysell, 8'h00);
    chk("rst_ts",   tx_timestamp, 32'h0);
    reset_n = 1'b1;

    // Idle until the counter reaches 7, then a single request from index 2.
    repeat (7) begin tick(); chk_idle("idle"); end
    req_valid = 4'b0100; tx_ready = 1'b1;
    push_grant(2);
    tick(); check_grant("single");
    req_valid = 4'b0000;
    tick(); chk_idle("single_drop");

    // Stall: index 1 granted, tx_ready held low for five edges while others request.
    req_valid = 4'b0010; tx_ready = 1'b0;
    push_grant(1);
    tick(); check_grant("stall");
    req_valid = 4'b1101;
    repeat (5) begin tick(); chk_hold("stall_hold"); end
    tx_ready = 1'b1;
    tick(); chk_idle("stall_release");
    req_valid = 4'b0000;
    tick(); chk_idle("stall_after");

    // Fresh reset, then all four requesting continuously.
    reset_n = 1'b0; #2; reset_n = 1'b1;
    req_valid = 4'b1111; tx_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      push_grant(rr_seq[j]);
      tick(); check_grant("rr");
      tick(); chk_idle("rr_gap");
    end

    // Asynchronous reset during HOLD, then re-presented request.
    req_valid = 4'b1000; tx_ready = 1'b0;
    push_grant(3);
    tick(); check_grant("pre_rst");
    #1 reset_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_addr", tx_addr, 8'h00);
    chk("mid_rst_ts",   tx_timestamp, 32'h0);
    #1 reset_n = 1'b1;
    tx_ready = 1'b1;
    push_grant(3);
    tick(); check_grant("regrant");
    req_valid = 4'b0000;
    tick(); chk_idle("regrant_drop");
    repeat (10) begin tick(); chk_idle("idle10"); end

    // Timestamp wrap on the narrow-counter instance; single requester re-granted.
    for (int n = 0; n < 20 && m_ts[3:0] != 4'hF; n++) tick();
    w_valid = 2'b01;
    tick();
    chk("wrap_dv",   w_dv, 1'b1);
    chk("wrap_ts",   w_ts, 4'hF);
    chk("wrap_rdy",  w_ready, 2'b01);
    chk("wrap_addr", w_tx_addr, 8'h20);
    tick();
    chk("wrap_gap_dv", w_dv, 1'b0);
    tick();
    chk("wrap2_dv",  w_dv, 1'b1);
    chk("wrap2_ts",  w_ts, 4'h1);
    chk("wrap2_rdy", w_ready, 2'b01);
    w_valid = 2'b00;
    tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
